// File: rtl/ysyx_22050078_ifu_fetch_queue.sv
// Pipelined fetch unit: credit-limited in-order memory requests, PC side queue and registered output FIFO.
// Optional YSYX_22050078_IFU_TRACE_EN adds a handshake trace and input sanity checks (simulation only).
module ysyx_22050078_ifu_fetch_queue #(
  parameter int                   CPU_WIDTH  = 64,
  parameter int                   INST_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = 64'h80000000,
  parameter int                   FQ_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_redirect,
  input  logic [CPU_WIDTH-1:0]  i_redirect_pc,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [CPU_WIDTH-1:0]  o_mem_req_addr,
  input  logic                  i_mem_rsp_valid,
  input  logic [CPU_WIDTH-1:0]  i_mem_rsp_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CPU_WIDTH-1:0]  o_pc,
  output logic [INST_WIDTH-1:0] o_inst
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FQ_DEPTH);

  logic [CPU_WIDTH-1:0]  fetch_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         fq_count;
  logic [PW-1:0]         fq_rd;
  logic [PW-1:0]         fq_wr;
  logic [PW-1:0]         sq_rd;
  logic [PW-1:0]         sq_wr;
  logic [CPU_WIDTH-1:0]  fq_pc   [FQ_DEPTH];
  logic [INST_WIDTH-1:0] fq_inst [FQ_DEPTH];
  logic [CPU_WIDTH-1:0]  sq_pc   [FQ_DEPTH];

  logic [CW:0]           credit_used;
  logic                  req_fire;
  logic                  push;
  logic                  pop;
  logic [CPU_WIDTH-1:0]  rsp_pc;
  logic [INST_WIDTH-1:0] rsp_inst;
  logic [CW-1:0]         rsp_dec;
  logic [CW-1:0]         fire_inc;

  // Buffered plus in-flight never exceeds the FIFO depth, so every response has a slot.
  assign credit_used     = {1'b0, fq_count} + {1'b0, outstanding};
  assign o_mem_req_valid = !rst && !i_redirect && (credit_used < DEPTH_W);
  assign o_mem_req_addr  = {fetch_pc[CPU_WIDTH-1:3], 3'b000};
  assign req_fire        = o_mem_req_valid && i_mem_req_ready;

  assign rsp_pc   = sq_pc[sq_rd];
  assign rsp_inst = rsp_pc[2] ? i_mem_rsp_data[2*INST_WIDTH-1:INST_WIDTH]
                              : i_mem_rsp_data[INST_WIDTH-1:0];
  assign rsp_dec  = CW'(i_mem_rsp_valid);
  assign fire_inc = CW'(req_fire);

  assign push    = i_mem_rsp_valid && !i_redirect && (drop_cnt == '0);
  assign o_valid = (fq_count != '0);
  assign pop     = o_valid && i_ready && !i_redirect;
  assign o_pc    = o_valid ? fq_pc[fq_rd]   : '0;
  assign o_inst  = o_valid ? fq_inst[fq_rd] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fq_count    <= '0;
      fq_rd       <= '0;
      fq_wr       <= '0;
      sq_rd       <= '0;
      sq_wr       <= '0;
    end else begin
      outstanding <= outstanding + fire_inc - rsp_dec;
      // The side queue tracks every request, dropped ones included, so it never flushes.
      if (req_fire) begin
        fetch_pc <= fetch_pc + CPU_WIDTH'(4);
        sq_wr    <= sq_wr + 1'b1;
      end
      if (i_mem_rsp_valid) sq_rd <= sq_rd + 1'b1;
      if (i_redirect) begin
        fetch_pc <= i_redirect_pc;
        drop_cnt <= outstanding - rsp_dec;
        fq_count <= '0;
        fq_rd    <= '0;
        fq_wr    <= '0;
      end else begin
        if (i_mem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (push) fq_wr <= fq_wr + 1'b1;
        if (pop)  fq_rd <= fq_rd + 1'b1;
        fq_count <= fq_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) sq_pc[sq_wr] <= fetch_pc;
    if (push) begin
      fq_pc[fq_wr]   <= rsp_pc;
      fq_inst[fq_wr] <= rsp_inst;
    end
  end

`ifdef YSYX_22050078_IFU_TRACE_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (o_valid && i_ready) $display("pc = %h inst = %h", o_pc, o_inst);
      if (i_redirect && (i_redirect_pc[1:0] != 2'b00))
        $error("ifu: misaligned redirect pc %h", i_redirect_pc);
      if (i_mem_rsp_valid && (outstanding == '0))
        $error("ifu: memory response with no request outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050078_ifu_fetch_queue.sv
// Bench for ysyx_22050078_ifu_fetch_queue: queue-level reference model, in-order random-latency memory,
// directed scenarios with literal expectations followed by a randomized run.
module tb_ysyx_22050078_ifu_fetch_queue;
  localparam logic [63:0] RPC = 64'h80000000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_redirect = 1'b0;
  logic [63:0] i_redirect_pc = '0;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready = 1'b0;
  logic [63:0] o_mem_req_addr;
  logic        i_mem_rsp_valid = 1'b0;
  logic [63:0] i_mem_rsp_data = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [63:0] o_pc;
  logic [31:0] o_inst;

  always #5 clk = ~clk;

  ysyx_22050078_ifu_fetch_queue dut (
    .clk(clk), .rst(rst),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_addr(o_mem_req_addr),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_inst(o_inst)
  );

  typedef struct { logic [63:0] pc; int due; } pend_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;

  pend_t       pend[$];
  ent_t        fq[$];
  logic [63:0] m_pc;
  int          m_out, m_drop;
  int          cyc, last_due, lat_min, lat_max;
  int          vectors, miscompares;
  logic        s_redir, s_mready, s_iready;
  logic [63:0] s_rpc;
  logic        ob_valid, ob_req, ob_fire, ob_hs;
  logic [63:0] ob_pc, ob_addr;
  logic [31:0] ob_inst;

  function automatic logic [31:0] inst_of(logic [63:0] pc);
    logic [31:0] a;
    a = pc[31:0] & 32'hFFFF_FFF8;
    return a ^ (pc[2] ? 32'hDEAD0004 : 32'h0BAD0000);
  endfunction

  function automatic logic [63:0] word_at(logic [63:0] addr);
    return {addr[31:0] ^ 32'hDEAD0004, addr[31:0] ^ 32'h0BAD0000};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    logic        rv;
    logic [63:0] rsp_pc;
    logic        exp_req;
    bit          fire, pop;
    int          lat, due;
    ent_t        e;
    pend_t       p;
    rv = 1'b0;
    rsp_pc = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      rsp_pc = pend[0].pc;
      void'(pend.pop_front());
    end
    i_redirect      = s_redir;
    i_redirect_pc   = s_rpc;
    i_mem_req_ready = s_mready;
    i_ready         = s_iready;
    i_mem_rsp_valid = rv;
    i_mem_rsp_data  = rv ? word_at(rsp_pc & ~64'h7) : {$urandom, $urandom};
    @(negedge clk);
    exp_req = !s_redir && ((fq.size() + m_out) < DEPTH);
    chk("req_valid", 64'(o_mem_req_valid), 64'(exp_req));
    if (exp_req) chk("req_addr", o_mem_req_addr, m_pc & ~64'h7);
    chk("o_valid", 64'(o_valid), 64'(fq.size() > 0));
    chk("o_pc", o_pc, (fq.size() > 0) ? fq[0].pc : 64'h0);
    chk("o_inst", 64'(o_inst), (fq.size() > 0) ? 64'(fq[0].inst) : 64'h0);
    ob_valid = o_valid;
    ob_req   = o_mem_req_valid;
    ob_pc    = o_pc;
    ob_inst  = o_inst;
    ob_addr  = o_mem_req_addr;
    ob_fire  = o_mem_req_valid && s_mready;
    ob_hs    = o_valid && s_iready && !s_redir;
    fire = exp_req && s_mready;
    pop  = (fq.size() > 0) && s_iready && !s_redir;
    if (s_redir) begin
      fq.delete();
      m_drop = m_out - int'(rv);
      m_pc   = s_rpc;
    end else begin
      if (pop) void'(fq.pop_front());
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else begin
          e.pc = rsp_pc;
          e.inst = inst_of(rsp_pc);
          fq.push_back(e);
        end
      end
      if (fire) begin
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        p.pc = m_pc;
        p.due = due;
        pend.push_back(p);
        m_pc = m_pc + 64'd4;
      end
    end
    m_out = m_out + int'(fire) - int'(rv);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    i_redirect = 1'b0;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_ready = 1'b0;
    #1;
    chk("rst_req_valid", 64'(o_mem_req_valid), 64'h0);
    chk("rst_o_valid", 64'(o_valid), 64'h0);
    chk("rst_o_pc", o_pc, 64'h0);
    chk("rst_o_inst", 64'(o_inst), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend.delete();
    fq.delete();
    m_pc = RPC;
    m_out = 0;
    m_drop = 0;
    last_due = cyc;
  endtask

  task automatic wait_first_valid(string name, logic [63:0] exp_pc);
    bit found;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (ob_valid) begin
        found = 1;
        chk({name, "_pc"}, ob_pc, exp_pc);
        chk({name, "_inst"}, 64'(ob_inst), 64'(inst_of(exp_pc)));
      end
    end
    if (!found) chk({name, "_timeout"}, 64'h0, 64'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t1_pc [3];
    logic [31:0] t1_inst [3];
    int          n;
    bit          hit;
    vectors = 0; miscompares = 0; cyc = 0; last_due = 0;
    s_redir = 0; s_rpc = '0; s_mready = 1; s_iready = 1;
    lat_min = 1; lat_max = 1;
    m_pc = RPC; m_out = 0; m_drop = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Streaming: one instruction per cycle, low/high/low halves
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i >= 2 && i <= 4) begin
        t1_pc[i-2] = ob_pc;
        t1_inst[i-2] = ob_inst;
      end
    end
    chk("t1_pc0", t1_pc[0], 64'h80000000);
    chk("t1_pc1", t1_pc[1], 64'h80000004);
    chk("t1_pc2", t1_pc[2], 64'h80000008);
    chk("t1_inst0", 64'(t1_inst[0]), 64'h8BAD0000);
    chk("t1_inst1", 64'(t1_inst[1]), 64'h5EAD0004);
    chk("t1_inst2", 64'(t1_inst[2]), 64'h8BAD0008);

    // IDU stalled: credits cap the number of requests
    do_reset();
    s_iready = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (ob_fire) n++;
    end
    chk("t2_fires", 64'(n), 64'd4);
    chk("t2_req_valid", 64'(ob_req), 64'h0);
    chk("t2_o_pc", ob_pc, 64'h80000000);

    // Redirect with three requests in flight
    do_reset();
    s_iready = 1; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 3; i++) cycle();
    chk("t3_outstanding_model", 64'(m_out), 64'd3);
    s_redir = 1; s_rpc = 64'h80001000;
    cycle();
    s_redir = 0;
    wait_first_valid("t3_first", 64'h80001000);

    // Redirect coinciding with a response and an IDU pop
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) cycle();
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (fq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc) hit = 1;
      else cycle();
    end
    chk("t4_setup", 64'(hit), 64'h1);
    s_redir = 1; s_rpc = 64'h80002000;
    cycle();
    s_redir = 0;
    cycle();
    chk("t4_flushed", 64'(ob_valid), 64'h0);
    wait_first_valid("t4_first", 64'h80002000);

    // Full FIFO drained while refilling: sequential PCs, no loss or duplicate
    do_reset();
    s_iready = 0;
    for (int i = 0; i < 8; i++) cycle();
    chk("t5_full", 64'(ob_valid), 64'h1);
    s_iready = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (ob_hs) begin
        chk("t5_seq", ob_pc, 64'h80000000 + 64'(4 * n));
        n++;
      end
    end
    chk("t5_any", 64'(n >= 10), 64'h1);

    // Randomized traffic with occasional redirects and mid-stream resets
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      s_mready = ($urandom % 4) != 0;
      s_iready = ($urandom % 3) != 0;
      s_redir  = ($urandom % 20) == 0;
      s_rpc    = {32'h0, 32'h80000000 | ($urandom & 32'h000F_FFFC)};
      if (i % 1000 == 999) begin
        do_reset();
        s_redir = 0;
        cycle();
        chk("t6_first_req", 64'(ob_req), 64'h1);
        chk("t6_first_addr", ob_addr, 64'h80000000);
      end else begin
        cycle();
      end
    end
    s_redir = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
